// File: rtl/video_pkg.sv
// Shared video timing constants and pixel type for the scanout path.
package video_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam logic SYNC_POL_DEF = 1'b0;
    localparam int   CNT_W        = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/video_timing_gen.sv
// Free-running raster counters with counter-aligned sync windows, row-buffer
// column address and PPU control pulses.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    output logic       active,
    output logic       hsync_win,
    output logic       vsync_win,
    output logic [8:0] col,
    output logic       swap,
    output logic       vb_start,
    output logic       vb_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hcount, vcount, h_nxt, v_nxt;
    logic             active_nxt;

    always_comb begin
        h_nxt = hcount + 1'b1;
        v_nxt = vcount;
        if (hcount == H_LAST) begin
            h_nxt = '0;
            v_nxt = (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end
        active_nxt = (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
    end

    assign active    = (hcount < H_ACT_C) && (vcount < V_ACT_C);
    assign hsync_win = (hcount >= HS_START) && (hcount < HS_END);
    assign vsync_win = (vcount >= VS_START) && (vcount < VS_END);

    // Registered outputs are decoded from the next position so they line up
    // with the counter value of the cycle in which they are seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount   <= '0;
            vcount   <= '0;
            col      <= '0;
            swap     <= 1'b0;
            vb_start <= 1'b0;
            vb_end   <= 1'b0;
        end else begin
            hcount   <= h_nxt;
            vcount   <= v_nxt;
            col      <= active_nxt ? h_nxt[CNT_W-1:1] : '0;
            swap     <= (h_nxt == H_LAST) && (v_nxt < V_ACT_C) && v_nxt[0];
            vb_start <= (h_nxt == '0) && (v_nxt == V_ACT_C);
            vb_end   <= (h_nxt == H_LAST) && (v_nxt == V_LAST);
        end
    end

endmodule

// File: rtl/ppu_scanout.sv
// Scans the PPU front row buffer out as 640x480 video, pixel/line doubled,
// with palette lookup and sync/DE aligned to the 3-cycle pixel pipe.
module ppu_scanout
    import video_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = SYNC_POL_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [8:0]  rowram_rdaddr,
    input  logic [9:0]  rowram_rddata,
    output logic [8:0]  palram_rdaddr,
    input  logic [63:0] palram_rddata,
    output logic        rowram_swap,
    output logic        vblank_start,
    output logic        vblank_end,
    output logic [23:0] hdmi_rgb,
    output logic        hdmi_hsync,
    output logic        hdmi_vsync,
    output logic        hdmi_de
);

    logic       active, hsync_win, vsync_win;
    logic       half_sel;
    logic [1:0] de_q, hs_q, vs_q;
    rgb_t       colour;
    logic       unused_pal_bits;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .active    (active),
        .hsync_win (hsync_win),
        .vsync_win (vsync_win),
        .col       (rowram_rdaddr),
        .swap      (rowram_swap),
        .vb_start  (vblank_start),
        .vb_end    (vblank_end)
    );

    // Row entry addresses the palette directly; the RAM register is stage 1's delay.
    assign palram_rdaddr   = rowram_rddata[9:1];
    assign colour          = half_sel ? rgb_t'(palram_rddata[55:32]) : rgb_t'(palram_rddata[23:0]);
    assign unused_pal_bits = ^{palram_rddata[63:56], palram_rddata[31:24]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_sel   <= 1'b0;
            de_q       <= '0;
            hs_q       <= '0;
            vs_q       <= '0;
            hdmi_rgb   <= '0;
            hdmi_de    <= 1'b0;
            hdmi_hsync <= ~SYNC_POL;
            hdmi_vsync <= ~SYNC_POL;
        end else begin
            half_sel   <= rowram_rddata[0];
            de_q       <= {de_q[0], active};
            hs_q       <= {hs_q[0], hsync_win};
            vs_q       <= {vs_q[0], vsync_win};
            hdmi_de    <= de_q[1];
            hdmi_rgb   <= de_q[1] ? colour : '0;
            hdmi_hsync <= hs_q[1] ? SYNC_POL : ~SYNC_POL;
            hdmi_vsync <= vs_q[1] ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_ppu_scanout.sv
// Directed bench for ppu_scanout with a shortened vertical raster so two
// whole frames fit in a short run; horizontal timing is the real 800-pixel line.
module tb_ppu_scanout;

    localparam int HA = 640, HF = 16, HS = 96, HB = 48, HT = 800;
    localparam int VA = 8, VF = 2, VS = 2, VB = 2, VT = 14;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  rowram_rdaddr;
    logic [9:0]  rowram_rddata;
    logic [8:0]  palram_rdaddr;
    logic [63:0] palram_rddata;
    logic        rowram_swap, vblank_start, vblank_end;
    logic [23:0] hdmi_rgb;
    logic        hdmi_hsync, hdmi_vsync, hdmi_de;

    logic [9:0]  row_mem [0:511];
    logic [63:0] pal_mem [0:511];

    int n_vec = 0;
    int n_err = 0;

    ppu_scanout #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rowram_rdaddr (rowram_rdaddr),
        .rowram_rddata (rowram_rddata),
        .palram_rdaddr (palram_rdaddr),
        .palram_rddata (palram_rddata),
        .rowram_swap   (rowram_swap),
        .vblank_start  (vblank_start),
        .vblank_end    (vblank_end),
        .hdmi_rgb      (hdmi_rgb),
        .hdmi_hsync    (hdmi_hsync),
        .hdmi_vsync    (hdmi_vsync),
        .hdmi_de       (hdmi_de)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rowram_rddata <= row_mem[rowram_rdaddr];
        palram_rddata <= pal_mem[palram_rdaddr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected colour for screen column x given the row/palette contents loaded below.
    function automatic logic [23:0] pix_rgb(input int x);
        case (x / 2)
            0, 5:    return 24'hAABBCC;
            6:       return 24'h112233;
            7:       return 24'hDDEEFF;
            8:       return 24'h102030;
            default: return 24'h000000;
        endcase
    endfunction

    int k, p, h, v, q, qh, qv;
    logic e_de, e_hs, e_vs, e_sw, e_vbs, e_vbe;
    logic [23:0] e_rgb;
    logic [8:0]  e_addr;
    int de_cnt, sw_cnt, vbs_cnt, vbe_k1, vbe_k2;
    int de_bad, hs_bad, vs_bad, rgb_bad, addr_bad, pulse_bad;
    int guard;
    logic [8:0] seq_addr [0:4];
    logic       seq_de   [0:4];

    initial begin
        for (int i = 0; i < 512; i++) begin
            row_mem[i] = '0;
            pal_mem[i] = '0;
        end
        row_mem[0] = 10'h003;
        row_mem[5] = 10'h003;
        row_mem[6] = 10'h002;
        row_mem[7] = 10'h005;
        row_mem[8] = 10'h004;
        pal_mem[1] = {32'h00AABBCC, 32'h00112233};
        pal_mem[2] = {32'hEEDDEEFF, 32'h77102030};
        seq_addr[0] = 9'd0; seq_addr[1] = 9'd0; seq_addr[2] = 9'd1; seq_addr[3] = 9'd1; seq_addr[4] = 9'd2;
        seq_de[0] = 1'b0; seq_de[1] = 1'b0; seq_de[2] = 1'b0; seq_de[3] = 1'b1; seq_de[4] = 1'b1;

        repeat (4) @(negedge clk);
        check("rst_addr", rowram_rdaddr, 0);
        check("rst_rgb", hdmi_rgb, 0);
        check("rst_de", hdmi_de, 0);
        check("rst_hsync", hdmi_hsync, 1);
        check("rst_vsync", hdmi_vsync, 1);
        check("rst_pulses", {rowram_swap, vblank_start, vblank_end}, 0);

        rst = 1'b0;
        de_cnt = 0; sw_cnt = 0; vbs_cnt = 0; vbe_k1 = -1; vbe_k2 = -1;
        de_bad = 0; hs_bad = 0; vs_bad = 0; rgb_bad = 0; addr_bad = 0; pulse_bad = 0;

        for (k = 0; k < 2 * FRAME + 5; k++) begin
            p = k % FRAME; h = p % HT; v = p / HT;
            e_addr = (h < HA && v < VA) ? 9'(h / 2) : 9'd0;
            e_sw   = (h == HT - 1) && (v < VA) && (v % 2 == 1);
            e_vbs  = (h == 0) && (v == VA);
            e_vbe  = (h == HT - 1) && (v == VT - 1);
            if (k < 3) begin
                qh = -1; qv = -1;
                e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_rgb = '0;
            end else begin
                q = (k - 3) % FRAME; qh = q % HT; qv = q / HT;
                e_de  = (qh < HA) && (qv < VA);
                e_hs  = !(qh >= HA + HF && qh < HA + HF + HS);
                e_vs  = !(qv >= VA + VF && qv < VA + VF + VS);
                e_rgb = e_de ? pix_rgb(qh) : 24'h0;
            end

            if (hdmi_de !== e_de) de_bad++;
            if (hdmi_hsync !== e_hs) hs_bad++;
            if (hdmi_vsync !== e_vs) vs_bad++;
            if (hdmi_rgb !== e_rgb) rgb_bad++;
            if (rowram_rdaddr !== e_addr) addr_bad++;
            if ({rowram_swap, vblank_start, vblank_end} !== {e_sw, e_vbs, e_vbe}) pulse_bad++;

            if (k >= 3 && k < FRAME + 3 && hdmi_de === 1'b1) de_cnt++;
            if (k < FRAME && rowram_swap === 1'b1) sw_cnt++;
            if (k < FRAME && vblank_start === 1'b1) vbs_cnt++;
            if (vblank_end === 1'b1) begin
                if (vbe_k1 < 0) vbe_k1 = k;
                else if (vbe_k2 < 0) vbe_k2 = k;
            end

            if (k < FRAME) begin
                if (h == HT - 1 && (v == 0 || v == 1 || v == VA - 1 || v == VA + 1))
                    check($sformatf("swap@%0d,%0d", h, v), rowram_swap, (v == 1 || v == VA - 1));
                if (qv == 2 && (qh == 0 || qh == 1 || qh == 10 || qh == 11 || qh == 12 ||
                                qh == 14 || qh == 16 || qh == 20))
                    check($sformatf("rgb@%0d", qh), hdmi_rgb, pix_rgb(qh));
                if (qv == 3 && (qh == 655 || qh == 656 || qh == 751 || qh == 752))
                    check($sformatf("hsync@%0d", qh), hdmi_hsync, (qh == 655 || qh == 752));
                if (qh == 0 && qv >= VA + VF - 1 && qv <= VA + VF + VS)
                    check($sformatf("vsync@line%0d", qv), hdmi_vsync, (qv == VA + VF - 1 || qv == VA + VF + VS));
                if (qv == 3 && qh == 700)
                    check("blank_rgb", hdmi_rgb, 0);
                if (v == 3 && h == 700)
                    check("blank_addr", rowram_rdaddr, 0);
            end
            @(negedge clk);
        end

        check("de_count", de_cnt, HA * VA);
        check("swap_count", sw_cnt, VA / 2);
        check("vbs_count", vbs_cnt, 1);
        check("vbe_first", vbe_k1, FRAME - 1);
        check("vbe_period", vbe_k2 - vbe_k1, FRAME);
        check("de_trace", de_bad, 0);
        check("hsync_trace", hs_bad, 0);
        check("vsync_trace", vs_bad, 0);
        check("rgb_trace", rgb_bad, 0);
        check("addr_trace", addr_bad, 0);
        check("pulse_trace", pulse_bad, 0);

        guard = 0;
        while ((k % FRAME) != 5 * HT + 300 && guard < FRAME) begin
            @(negedge clk);
            k++;
            guard++;
        end
        check("reach_midframe", guard < FRAME, 1);
        check("mid_addr", rowram_rdaddr, 150);

        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_rst_addr", rowram_rdaddr, 0);
        check("mid_rst_rgb", hdmi_rgb, 0);
        check("mid_rst_de", hdmi_de, 0);
        check("mid_rst_sync", {hdmi_hsync, hdmi_vsync}, 2'b11);
        check("mid_rst_pulses", {rowram_swap, vblank_start, vblank_end}, 0);

        rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            check($sformatf("rel_addr%0d", j), rowram_rdaddr, seq_addr[j]);
            check($sformatf("rel_de%0d", j), hdmi_de, seq_de[j]);
            if (j < 2)
                check($sformatf("rel_pulses%0d", j), {rowram_swap, vblank_start, vblank_end}, 0);
            if (j == 3)
                check("rel_rgb", hdmi_rgb, 24'hAABBCC);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
